// File: rtl/frame_ch_sequencer.sv
// frame_ch_sequencer: per-frame channel-index sequencer for bank 0.
// On each frame trigger, walks the channel index 0..NUM_CH-1 over a
// valid/ready handshake. It then emits the end-of-frame marker (value NUM_CH),
// counts accepted markers and flags triggers that arrive mid-frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   frame_start  single-cycle frame trigger
//   ch_ready     downstream accept
//   ch_out       channel index, NUM_CH marker, or 8'hFF when idle
//   ch_valid     ch_out valid
//   busy         frame in progress
//   overrun      one-cycle pulse for each dropped trigger
//   frames_sent  count of accepted end-of-frame markers (wraps mod 2^32)
module frame_ch_sequencer #(
    parameter int unsigned NUM_CH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        ch_ready,
    output logic [7:0]  ch_out,
    output logic        ch_valid,
    output logic        busy,
    output logic        overrun,
    output logic [31:0] frames_sent
);

    localparam int unsigned IDX_W = 8;
    localparam int unsigned CNT_W = 32;
    localparam logic [IDX_W-1:0] EOF_MARK  = IDX_W'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] IDLE_CODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EOF  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] ch_out_nxt;
    logic             overrun_nxt;
    logic             frame_done_c;
    logic             xfer_c;

    assign xfer_c = ch_valid & ch_ready;

    // Next-state, next-index and event decode
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        overrun_nxt  = 1'b0;
        frame_done_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_SCAN;
                    idx_nxt   = '0;
                end
            end
            ST_SCAN: begin
                // Triggers mid-scan are dropped; the current frame carries on
                overrun_nxt = frame_start;
                if (xfer_c) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_EOF;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            ST_EOF: begin
                if (xfer_c) begin
                    frame_done_c = 1'b1;
                    // A trigger coincident with the marker transfer chains
                    // the next frame with no idle gap
                    if (frame_start) begin
                        state_nxt = ST_SCAN;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    overrun_nxt = frame_start;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Output value follows the state being entered so outputs stay registered
    always_comb begin
        ch_out_nxt = IDLE_CODE;
        case (state_nxt)
            ST_SCAN: ch_out_nxt = idx_nxt;
            ST_EOF:  ch_out_nxt = EOF_MARK;
            default: ch_out_nxt = IDLE_CODE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            ch_out   <= IDLE_CODE;
            ch_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ch_out   <= ch_out_nxt;
            ch_valid <= (state_nxt != ST_IDLE);
            busy     <= (state_nxt != ST_IDLE);
            overrun  <= overrun_nxt;
        end
    end

    // Completed-frame counter, advanced only on an accepted marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_sent <= '0;
        end else if (frame_done_c) begin
            frames_sent <= frames_sent + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_frame_ch_sequencer.sv
// Self-checking bench for frame_ch_sequencer. Accepted stream, overrun
// pulses and the frame count are checked against a transaction-level model.
module tb_frame_ch_sequencer;

    localparam int unsigned NUM_CH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        ch_ready;
    logic [7:0]  ch_out;
    logic        ch_valid;
    logic        busy;
    logic        overrun;
    logic [31:0] frames_sent;

    int          total = 0;
    int          bad = 0;
    int          exp_pos = 0;
    logic [31:0] exp_frames = 32'd0;

    frame_ch_sequencer #(.NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .ch_ready    (ch_ready),
        .ch_out      (ch_out),
        .ch_valid    (ch_valid),
        .busy        (busy),
        .overrun     (overrun),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the model tracks which value should be accepted next,
    // whether the trigger is dropped, and the expected frame count.
    task automatic tick();
        logic xfer;
        logic mk;
        logic ovr_exp;
        xfer = ch_valid && ch_ready;
        mk   = 1'b0;
        if (xfer) begin
            chk("stream", 32'(ch_out), 32'(exp_pos));
            if (exp_pos == int'(NUM_CH)) begin
                exp_pos = 0;
                exp_frames = exp_frames + 32'd1;
                mk = 1'b1;
            end else begin
                exp_pos++;
            end
        end
        ovr_exp = frame_start && busy && !mk;
        @(posedge clk);
        #1;
        chk("overrun", 32'(overrun), 32'(ovr_exp));
        if (mk) chk("frames_sent", frames_sent, exp_frames);
    endtask

    // Advance with ready high until ch_out shows value v (bounded)
    task automatic wait_val(input int v);
        int n;
        n = 0;
        ch_ready = 1'b1;
        while (!(ch_valid && ch_out == 8'(v)) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("wait_val", 32'(ch_out), 32'(v));
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("start_idx0", 32'(ch_out), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        ch_ready = 1'b1;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("finish_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        ch_ready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ch_out", 32'(ch_out), 32'hFF);
        chk("rst_valid", 32'(ch_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frames", frames_sent, 32'd0);
        repeat (5) tick();

        // Full frame with ready held high: exact latency of each index
        start_frame();
        for (int k = 1; k < int'(NUM_CH); k++) begin
            tick();
            chk("full_idx", 32'(ch_out), 32'(k));
        end
        tick();
        chk("full_marker", 32'(ch_out), NUM_CH);
        chk("full_marker_valid", 32'(ch_valid), 32'd1);
        tick();
        chk("full_frames", frames_sent, 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_idle_out", 32'(ch_out), 32'hFF);
        tick();

        // Backpressure at index 7
        start_frame();
        wait_val(7);
        ch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 32'(ch_out), 32'd7);
            chk("stall_valid", 32'(ch_valid), 32'd1);
        end
        ch_ready = 1'b1;
        tick();
        chk("stall_next", 32'(ch_out), 32'd8);
        finish_frame();

        // Overrun at index 5, then back-to-back frame on the marker transfer
        start_frame();
        wait_val(5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_continue", 32'(ch_out), 32'd6);
        tick();
        chk("ovr_one_cycle", 32'(overrun), 32'd0);
        wait_val(int'(NUM_CH));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("b2b_idx0", 32'(ch_out), 32'd0);
        chk("b2b_no_ovr", 32'(overrun), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        finish_frame();
        chk("b2b_frames", frames_sent, exp_frames);

        // Trigger against a stalled marker is dropped
        start_frame();
        wait_val(int'(NUM_CH));
        ch_ready    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("eof_stall_ovr", 32'(overrun), 32'd1);
        chk("eof_stall_hold", 32'(ch_out), NUM_CH);
        ch_ready = 1'b1;
        tick();
        chk("eof_stall_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-frame at index 10
        start_frame();
        wait_val(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ch_out", 32'(ch_out), 32'hFF);
        chk("arst_valid", 32'(ch_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frames", frames_sent, 32'd0);
        exp_pos    = 0;
        exp_frames = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_frame();
        finish_frame();
        chk("arst_restart_frames", frames_sent, 32'd1);

        // Randomized ready and triggers against the model
        for (int c = 0; c < 1500; c++) begin
            ch_ready    = 1'($urandom_range(0, 1));
            frame_start = ($urandom_range(0, 15) == 0);
            tick();
        end
        frame_start = 1'b0;
        finish_frame();
        chk("rand_frames", frames_sent, exp_frames);

        // Counter wrap
        force dut.frames_sent = 32'hFFFF_FFFF;
        #1;
        release dut.frames_sent;
        exp_frames = 32'hFFFF_FFFF;
        chk("wrap_preset", frames_sent, 32'hFFFF_FFFF);
        tick();
        start_frame();
        finish_frame();
        chk("wrap_zero", frames_sent, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
